// File: rtl/acc_byte_serializer_if.sv
// Word-in / byte-out handshake bundle for acc_byte_serializer.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid & ready are both 1.
// A producer keeps its data stable while valid is 1 and ready is 0.
interface acc_byte_serializer_if;
  logic [39:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_last
  );

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_last
  );
endinterface

// File: rtl/acc_byte_serializer.sv
// Serializes a 40-bit accumulator sum into five bytes over a valid/ready stream.
// Words that arrive while a word is still being sent are dropped and counted.
module acc_byte_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  acc_byte_serializer_if.slave       bus,
  output logic [7:0]                 drop_cnt,
  output logic                       state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state;
  logic [39:0] hold;
  logic [2:0]  idx;

  // Byte position i in transmit order, mapped to its place in the word.
  function automatic logic [7:0] byte_at(input logic [39:0] w, input logic [2:0] i);
    logic [2:0] k;
    logic [7:0] b;
    k = MSB_FIRST ? (3'd4 - i) : i;
    case (k)
      3'd0:    b = w[7:0];
      3'd1:    b = w[15:8];
      3'd2:    b = w[23:16];
      3'd3:    b = w[31:24];
      3'd4:    b = w[39:32];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign bus.din_ready = (state == IDLE);
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      hold           <= 40'h0;
      idx            <= 3'd0;
      bus.dout       <= 8'h00;
      bus.dout_valid <= 1'b0;
      bus.dout_last  <= 1'b0;
      drop_cnt       <= 8'h00;
    end else begin
      // Any word offered while busy is lost, including one on the final transfer cycle.
      if (state == SEND && bus.din_valid && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (bus.din_valid) begin
            hold           <= bus.din;
            idx            <= 3'd0;
            state          <= SEND;
            bus.dout       <= byte_at(bus.din, 3'd0);
            bus.dout_valid <= 1'b1;
            bus.dout_last  <= 1'b0;
          end
        end
        SEND: begin
          if (bus.dout_ready) begin
            if (idx == 3'd4) begin
              state          <= IDLE;
              idx            <= 3'd0;
              bus.dout       <= 8'h00;
              bus.dout_valid <= 1'b0;
              bus.dout_last  <= 1'b0;
            end else begin
              idx           <= 3'(idx + 3'd1);
              bus.dout      <= byte_at(hold, 3'(idx + 3'd1));
              bus.dout_last <= (idx == 3'd3);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_byte_serializer.sv
// Directed bench for acc_byte_serializer: an MSB-first and an LSB-first instance driven by identical stimulus.
module tb_acc_byte_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] din;
  logic        din_valid;
  logic        dout_ready;

  logic [7:0]  m_drop, l_drop;
  logic        m_state, l_state;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_lq[$];

  acc_byte_serializer_if m_if();
  acc_byte_serializer_if l_if();

  assign m_if.din        = din;
  assign m_if.din_valid  = din_valid;
  assign m_if.dout_ready = dout_ready;
  assign l_if.din        = din;
  assign l_if.din_valid  = din_valid;
  assign l_if.dout_ready = dout_ready;

  acc_byte_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bus(m_if), .drop_cnt(m_drop), .state_dbg(m_state)
  );
  acc_byte_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bus(l_if), .drop_cnt(l_drop), .state_dbg(l_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [39:0] din;
    logic        rdy;
    logic        e_ready;
    logic        e_valid;
    logic [7:0]  e_msb;
    logic [7:0]  e_lsb;
    logic        e_last;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic dv, input logic [39:0] d, input logic rdy, input logic e_ready,
                     input logic e_valid, input logic [7:0] e_msb, input logic [7:0] e_lsb,
                     input logic e_last, input logic [7:0] e_drop);
    vec_t v;
    v.dv = dv; v.din = d; v.rdy = rdy; v.e_ready = e_ready; v.e_valid = e_valid;
    v.e_msb = e_msb; v.e_lsb = e_lsb; v.e_last = e_last; v.e_drop = e_drop;
    vecs.push_back(v);
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] e_drop);
    chk({tag, "_m_ready"}, m_if.din_ready, 1'b1);
    chk({tag, "_m_valid"}, m_if.dout_valid, 1'b0);
    chk({tag, "_m_dout"},  m_if.dout, 8'h00);
    chk({tag, "_m_last"},  m_if.dout_last, 1'b0);
    chk({tag, "_m_drop"},  m_drop, e_drop);
    chk({tag, "_l_ready"}, l_if.din_ready, 1'b1);
    chk({tag, "_l_valid"}, l_if.dout_valid, 1'b0);
    chk({tag, "_l_drop"},  l_drop, e_drop);
  endtask

  task automatic push_word(input logic [39:0] w);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(w[39-8*i -: 8]);
      exp_lq.push_back(w[8*i +: 8]);
    end
  endtask

  // Scoreboard: called at a negedge; pops one expected byte per accepted transfer.
  task automatic collect(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      if (m_if.dout_valid && dout_ready) begin
        chk("sb_m_last", m_if.dout_last, exp_q.size() == 1);
        chk("sb_l_last", l_if.dout_last, exp_lq.size() == 1);
        chk("sb_m_byte", m_if.dout, exp_q.pop_front());
        chk("sb_l_byte", l_if.dout, exp_lq.pop_front());
      end
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL sb_timeout: got %0d bytes left expected 0", exp_q.size());
      exp_q.delete();
      exp_lq.delete();
    end
  endtask

  localparam logic [39:0] W  = 40'h12_3456_789A;
  localparam logic [39:0] W2 = 40'hA1_B2C3_D4E5;
  localparam logic [39:0] JK = 40'h55_5555_5555;

  initial begin
    rst = 1'b0; din = 40'h0; din_valid = 1'b0; dout_ready = 1'b1;

    // reset: outputs quiet, din_ready high, no capture even with din_valid
    @(negedge clk);
    chk_idle("rst", 8'h00);
    din = W; din_valid = 1'b1;
    @(negedge clk);
    chk_idle("rst_nocap", 8'h00);
    din_valid = 1'b0;
    rst = 1'b1;

    // basic send
    add(1, W, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    add(0, 0, 1, 0, 1, 8'h12, 8'h9A, 0, 0);
    add(0, 0, 1, 0, 1, 8'h34, 8'h78, 0, 0);
    add(0, 0, 1, 0, 1, 8'h56, 8'h56, 0, 0);
    add(0, 0, 1, 0, 1, 8'h78, 8'h34, 0, 0);
    add(0, 0, 1, 0, 1, 8'h9A, 8'h12, 1, 0);
    // backpressure on the second byte
    add(1, W, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    add(0, 0, 1, 0, 1, 8'h12, 8'h9A, 0, 0);
    add(0, 0, 0, 0, 1, 8'h34, 8'h78, 0, 0);
    add(0, 0, 0, 0, 1, 8'h34, 8'h78, 0, 0);
    add(0, 0, 0, 0, 1, 8'h34, 8'h78, 0, 0);
    add(0, 0, 1, 0, 1, 8'h34, 8'h78, 0, 0);
    add(0, 0, 1, 0, 1, 8'h56, 8'h56, 0, 0);
    add(0, 0, 1, 0, 1, 8'h78, 8'h34, 0, 0);
    add(0, 0, 1, 0, 1, 8'h9A, 8'h12, 1, 0);
    // drops, the last one on the final transfer cycle
    add(1, W2, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    add(1, JK, 1, 0, 1, 8'hA1, 8'hE5, 0, 0);
    add(0, 0,  1, 0, 1, 8'hB2, 8'hD4, 0, 1);
    add(1, JK, 1, 0, 1, 8'hC3, 8'hC3, 0, 1);
    add(0, 0,  1, 0, 1, 8'hD4, 8'hB2, 0, 2);
    add(1, JK, 1, 0, 1, 8'hE5, 8'hA1, 1, 2);
    add(0, 0,  1, 1, 0, 8'h00, 8'h00, 0, 3);

    // driver loop: check this cycle's outputs, then drive this cycle's inputs
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_ready", i),   m_if.din_ready,  vecs[i].e_ready);
      chk($sformatf("v%0d_state", i),   m_state,         !vecs[i].e_ready);
      chk($sformatf("v%0d_m_valid", i), m_if.dout_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_m_dout", i),  m_if.dout,       vecs[i].e_msb);
      chk($sformatf("v%0d_m_last", i),  m_if.dout_last,  vecs[i].e_last);
      chk($sformatf("v%0d_m_drop", i),  m_drop,          vecs[i].e_drop);
      chk($sformatf("v%0d_l_valid", i), l_if.dout_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_l_dout", i),  l_if.dout,       vecs[i].e_lsb);
      chk($sformatf("v%0d_l_last", i),  l_if.dout_last,  vecs[i].e_last);
      chk($sformatf("v%0d_l_drop", i),  l_drop,          vecs[i].e_drop);
      din = vecs[i].din; din_valid = vecs[i].dv; dout_ready = vecs[i].rdy;
    end

    // drop counter saturation during a long stall (3 drops already counted)
    @(negedge clk);
    din = W; din_valid = 1'b1; dout_ready = 1'b1;
    @(negedge clk);
    din = JK; dout_ready = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (n == 251) chk("sat_254", m_drop, 8'd254);
      if (n == 252) chk("sat_255", m_drop, 8'd255);
      @(negedge clk);
    end
    chk("sat_hold_m", m_drop, 8'd255);
    chk("sat_hold_l", l_drop, 8'd255);
    chk("stall_m_dout", m_if.dout, 8'h12);
    chk("stall_l_dout", l_if.dout, 8'h9A);
    din_valid = 1'b0; dout_ready = 1'b1;
    push_word(W);
    collect(20);
    chk_idle("sat_done", 8'd255);

    // mid-word reset after two bytes, then first-edge capture after release
    din = W; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_m_dout", m_if.dout, 8'h56);
    rst = 1'b0;
    #1;
    chk_idle("mid_rst", 8'h00);
    din = W; din_valid = 1'b1;
    @(negedge clk);
    chk_idle("mid_rst_hold", 8'h00);
    rst = 1'b1;
    din = 40'hFF_0000_0001;
    @(negedge clk);
    din_valid = 1'b0;
    chk("first_cap_valid", m_if.dout_valid, 1'b1);
    chk("first_cap_dout", m_if.dout, 8'hFF);
    push_word(40'hFF_0000_0001);
    collect(20);
    chk_idle("post_rst", 8'h00);

    // back-to-back: din_valid held high with a fresh word every cycle
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("b2b%0d_ready", k), m_if.din_ready, (k % 6) == 0);
      if ((k % 6) == 1) begin
        chk($sformatf("b2b%0d_m_dout", k), m_if.dout, 8'(k - 1));
        chk($sformatf("b2b%0d_l_dout", k), l_if.dout, 8'(k - 1 + 16));
      end
      din = {8'(k), 8'hA0, 8'hB0, 8'hC0, 8'(k + 16)};
      din_valid = 1'b1; dout_ready = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    chk("b2b_drop_m", m_drop, 8'd15);
    chk("b2b_drop_l", l_drop, 8'd15);
    chk("b2b_ready", m_if.din_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_byte_serializer.md
ACC_BYTE_SERIALIZER -- requirements
Module: acc_byte_serializer

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 1: 1 = most-significant byte sent first, 0 = least-significant byte first.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port din, input, 40 bits: accumulator-sum word from the upstream dual-accumulator stage.
REQ-005 The block SHALL have port din_valid, input, 1 bit: din holds a word to capture.
REQ-006 The block SHALL have port din_ready, output, 1 bit: block can capture a word this cycle.
REQ-007 The block SHALL have port dout, output, 8 bits: current serial byte.
REQ-008 The block SHALL have port dout_valid, output, 1 bit: dout is valid.
REQ-009 The block SHALL have port dout_ready, input, 1 bit: downstream accepts dout this cycle.
REQ-010 The block SHALL have port dout_last, output, 1 bit: current byte is the fifth and final byte of the word.
REQ-011 The block SHALL have port drop_cnt, output, 8 bits: count of words lost while busy.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and SEND; din_ready = 1 exactly when state = IDLE.
REQ-013 The block SHALL capture din into a 40-bit holding register when din_valid & din_ready at a rising edge, clear byte index to 0, and enter SEND.
REQ-014 In SEND, dout_valid SHALL be 1 and dout SHALL present byte[index]: MSB_FIRST=1 gives index 0 = din[39:32] through index 4 = din[7:0]; MSB_FIRST=0 reverses the order.
REQ-015 A byte transfer SHALL occur on a rising edge with dout_valid & dout_ready; the index then increments.
REQ-016 dout, dout_last and the index SHALL hold stable while dout_valid & !dout_ready, for any number of stall cycles.
REQ-017 dout_last SHALL be 1 only in SEND with index = 4.
REQ-018 A transfer at index 4 SHALL return the FSM to IDLE; din_ready rises the following cycle.
REQ-019 Minimum word period SHALL be 6 cycles: 1 capture cycle plus 5 byte cycles.
REQ-020 In IDLE, dout_valid, dout_last and dout SHALL all be 0.
REQ-021 When din_valid = 1 at a rising edge while state = SEND, the word SHALL be discarded and drop_cnt SHALL increment by 1, saturating at 255 with no wrap.
REQ-022 A word present in the same cycle as the final transfer SHALL be counted as dropped, because din_ready is 0 in that cycle.
REQ-023 The holding register SHALL be unaffected by din while in SEND.

Reset
REQ-024 While rst = 0, the block SHALL force state = IDLE, holding register = 0, index = 0, dout = 0, dout_valid = 0, dout_last = 0 and drop_cnt = 0.
REQ-025 During reset, din_ready SHALL read 1, and no capture SHALL occur.
REQ-026 Reset asserted mid-word SHALL abort the word immediately; remaining bytes are discarded and not resumed.
REQ-027 After rst deasserts, the first capture SHALL be possible at the first rising edge.

Verification
REQ-028 Scenario, basic send: MSB_FIRST=1, din=40'h12_3456_789A, single-cycle din_valid, dout_ready=1 -> dout = 12,34,56,78,9A on 5 consecutive cycles; dout_last only on 9A; din_ready = 0 for 5 cycles.
REQ-029 Scenario, backpressure: same word, dout_ready = 0 for 3 cycles while dout = 34 -> 34 held for 4 cycles, then 56,78,9A; no byte lost or duplicated.
REQ-030 Scenario, drops: din_valid pulsed on 3 separate SEND cycles -> drop_cnt = 3 and the output word is unchanged. Then 300 drop events -> drop_cnt = 255.
REQ-031 Scenario, LSB first: MSB_FIRST=0, din=40'h12_3456_789A -> dout = 9A,78,56,34,12; dout_last on 12.
REQ-032 Scenario, mid-word reset: rst = 0 after 2 bytes are transferred -> dout_valid = 0 and drop_cnt = 0 immediately. After release, din=40'hFF_0000_0001 -> dout = FF,00,00,00,01.
REQ-033 Scenario, back-to-back words: din_valid held high continuously with a new word each cycle -> one word captured per 6 cycles, and drop_cnt increments once per SEND cycle with din_valid = 1.
